// File: rtl/store_unit.sv
// Store unit: serialises a 1/4/8-byte register value onto a byte-wide memory
// write port, little-endian. Define STORE_ALIGN_CHECK_EN to reject misaligned stores.
module store_unit #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [63:0]       st_data,
  input  logic [1:0]        st_size,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              st_done,
  output logic              st_err
);

  // Handshakes: a request transfers on an edge with st_valid & st_ready;
  // a memory beat transfers on an edge with mem_req & mem_ack.
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_e;

  state_e            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [63:0]       data_q, data_d;
  logic              last_beat;
`ifdef STORE_ALIGN_CHECK_EN
  logic              err_q, err_d;
  logic              misaligned;

  assign misaligned = ((st_size == 2'd1) && (st_addr[1:0] != 2'b00)) ||
                      (st_size[1] && (st_addr[2:0] != 3'b000));
`endif

  assign last_beat = ({1'b0, idx_q} == (cnt_q - 4'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef STORE_ALIGN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
`ifdef STORE_ALIGN_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
`ifdef STORE_ALIGN_CHECK_EN
    err_d     = err_q;
`endif
    st_ready  = 1'b0;
    mem_req   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    st_done   = 1'b0;
    st_err    = 1'b0;

    case (state_q)
      IDLE: begin
        st_ready = 1'b1;
        if (st_valid) begin
          addr_d = st_addr;
          data_d = st_data;
          idx_d  = '0;
          case (st_size)
            2'd0:    cnt_d = 4'd1;
            2'd1:    cnt_d = 4'd4;
            default: cnt_d = 4'd8;
          endcase
`ifdef STORE_ALIGN_CHECK_EN
          err_d   = misaligned;
          state_d = misaligned ? DONE : WRITE;
`else
          state_d = WRITE;
`endif
        end
      end
      WRITE: begin
        // Address/data are pure functions of held registers, so they stay frozen while stalled.
        mem_req   = 1'b1;
        mem_addr  = addr_q + ADDR_W'(idx_q);
        mem_wdata = data_q[{idx_q, 3'b000} +: 8];
        if (mem_ack) begin
          if (last_beat) state_d = DONE;
          else           idx_d   = idx_q + 3'd1;
        end
      end
      DONE: begin
        st_done = 1'b1;
`ifdef STORE_ALIGN_CHECK_EN
        st_err  = err_q;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: directed table, reset-abort sequence and
// random stores checked against a byte-list model of little-endian serialisation.
module tb_store_unit;

`ifdef STORE_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [15:0] st_addr;
  logic [63:0] st_data;
  logic [1:0]  st_size;
  logic        mem_req;
  logic        mem_ack;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        st_done;
  logic        st_err;

  int checks = 0;
  int errors = 0;

  // Expected beats, each packed as {address, byte}.
  logic [23:0] exp_q[$];

  typedef struct {
    logic [15:0] addr;
    logic [63:0] data;
    logic [1:0]  size;
    int          stall_beat;
    int          stall_len;
    int          exp_n;
    logic [23:0] exp_last;
  } vec_t;

  vec_t vecs[7];

  store_unit #(.ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .st_done(st_done), .st_err(st_err)
  );

  always #5 clk = ~clk;

  function automatic bit chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
      return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int model_count(logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 4 : 8;
  endfunction

  function automatic bit model_err(logic [15:0] a, logic [1:0] sz);
    if (!ALIGN) return 1'b0;
    if (sz == 2'd1) return (int'(a) % 4) != 0;
    if (sz >= 2'd2) return (int'(a) % 8) != 0;
    return 1'b0;
  endfunction

  task automatic do_store(input logic [15:0] a, input logic [63:0] d, input logic [1:0] sz,
                          input int stall_beat, input int stall_len,
                          input bit rand_ack, input bit hold_valid,
                          output int n_seen, output logic [23:0] last_beat);
    int  n, beats, stall_cnt, guard;
    bit  e, ack;
    logic [15:0] ba;
    logic [7:0]  bb;
    n = model_count(sz);
    e = model_err(a, sz);
    exp_q.delete();
    if (!e) begin
      for (int i = 0; i < n; i++) begin
        ba = 16'((int'(a) + i) % 65536);
        bb = 8'((d >> (8 * i)) & 64'hFF);
        exp_q.push_back({ba, bb});
      end
    end
    n_seen = 0;
    last_beat = '0;

    @(negedge clk);
    st_valid = 1'b1; st_addr = a; st_data = d; st_size = sz; mem_ack = 1'b0;
    void'(chk("accept_ready", st_ready, 1));
    @(negedge clk);
    if (!hold_valid) st_valid = 1'b0;
    else begin
      st_addr = 16'($urandom); st_data = {$urandom, $urandom}; st_size = 2'($urandom);
    end

    if (e) begin
      void'(chk("err_no_req", mem_req, 0));
      void'(chk("err_done", st_done, 1));
      void'(chk("err_flag", st_err, 1));
      @(negedge clk);
      void'(chk("err_done_clear", st_done, 0));
      void'(chk("err_ready_back", st_ready, 1));
      st_valid = 1'b0;
      return;
    end

    beats = 0; stall_cnt = 0; guard = 0;
    while (exp_q.size() > 0 && guard < 1000) begin
      if (!chk("beat_req", mem_req, 1)) break;
      void'(chk("beat_data", {mem_addr, mem_wdata}, exp_q[0]));
      void'(chk("beat_no_done", st_done, 0));
      if (rand_ack) ack = ($urandom_range(0, 2) != 0);
      else if (beats == stall_beat && stall_cnt < stall_len) begin
        ack = 1'b0; stall_cnt++;
      end else ack = 1'b1;
      mem_ack = ack;
      if (ack) begin
        last_beat = {mem_addr, mem_wdata};
        void'(exp_q.pop_front());
        n_seen++; beats++;
      end
      guard++;
      @(negedge clk);
    end
    if (exp_q.size() > 0) begin
      errors++; checks++;
      $display("FAIL beat_timeout: got %0d beats expected %0d", n_seen, n);
      exp_q.delete();
    end
    mem_ack = rand_ack ? 1'($urandom_range(0, 1)) : 1'b0;
    void'(chk("done_req_low", mem_req, 0));
    void'(chk("done_pulse", st_done, 1));
    void'(chk("done_no_err", st_err, 0));
    void'(chk("done_not_ready", st_ready, 0));
    @(negedge clk);
    mem_ack = 1'b0;
    void'(chk("done_clear", st_done, 0));
    void'(chk("ready_back", st_ready, 1));
    st_valid = 1'b0;
  endtask

  initial begin
    int          n_seen, exp_n;
    logic [23:0] last;
    logic [15:0] ra;
    logic [63:0] rd;
    logic [1:0]  rs;

    vecs[0] = '{16'h0010, 64'hDEADBEEF_CAFE00A5, 2'd0, -1, 0, 1, 24'h0010A5};
    vecs[1] = '{16'h0100, 64'hFFFFFFFF_12345678, 2'd1, -1, 0, 4, 24'h010312};
    vecs[2] = '{16'h0200, 64'h08070605_04030201, 2'd2,  2, 3, 8, 24'h020708};
    vecs[3] = '{16'hFFFC, 64'h88776655_44332211, 2'd2, -1, 0,
                ALIGN ? 0 : 8, ALIGN ? 24'h0 : 24'h000388};
    vecs[4] = '{16'h1008, 64'hA1B2C3D4_E5F60718, 2'd3,  5, 1, 8, 24'h100FA1};
    vecs[5] = '{16'h0102, 64'h00000000_CAFEBABE, 2'd1, -1, 0,
                ALIGN ? 0 : 4, ALIGN ? 24'h0 : 24'h0105CA};
    vecs[6] = '{16'h0104, 64'h00000000_CAFEBABE, 2'd1, -1, 0, 4, 24'h0107CA};

    rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0; mem_ack = 1'b0;
    #12;
    void'(chk("rst_ready", st_ready, 1));
    void'(chk("rst_req", mem_req, 0));
    void'(chk("rst_addr", mem_addr, 0));
    void'(chk("rst_wdata", mem_wdata, 0));
    void'(chk("rst_done", st_done, 0));
    void'(chk("rst_err", st_err, 0));
    @(negedge clk);
    rst_n = 1'b1;

    // Acks while idle must be ignored.
    mem_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      void'(chk("idle_ack_req", mem_req, 0));
      void'(chk("idle_ack_ready", st_ready, 1));
    end
    mem_ack = 1'b0;

    foreach (vecs[i]) begin
      do_store(vecs[i].addr, vecs[i].data, vecs[i].size, vecs[i].stall_beat,
               vecs[i].stall_len, 1'b0, (i % 2) == 1, n_seen, last);
      void'(chk($sformatf("vec%0d_beats", i), n_seen, vecs[i].exp_n));
      void'(chk($sformatf("vec%0d_last", i), last, vecs[i].exp_last));
    end

    // Reset in the middle of an 8-byte store aborts without a done pulse.
    @(negedge clk);
    st_valid = 1'b1; st_addr = 16'h0300; st_data = 64'h11223344_55667788; st_size = 2'd2;
    @(negedge clk);
    st_valid = 1'b0; mem_ack = 1'b1;
    void'(chk("abort_beat0", {mem_addr, mem_wdata}, 24'h030088));
    @(negedge clk);
    void'(chk("abort_beat1", {mem_addr, mem_wdata}, 24'h030177));
    @(negedge clk);
    mem_ack = 1'b0;
    void'(chk("abort_req_before", mem_req, 1));
    void'(chk("abort_beat2", {mem_addr, mem_wdata}, 24'h030266));
    #2 rst_n = 1'b0;
    #1;
    void'(chk("abort_req_async", mem_req, 0));
    void'(chk("abort_ready", st_ready, 1));
    void'(chk("abort_addr", mem_addr, 0));
    repeat (3) begin
      @(negedge clk);
      void'(chk("abort_no_done", st_done, 0));
    end
    rst_n = 1'b1;
    do_store(16'h0040, 64'h5A, 2'd0, -1, 0, 1'b0, 1'b0, n_seen, last);
    void'(chk("post_reset_beats", n_seen, 1));
    void'(chk("post_reset_last", last, 24'h00405A));

    // Random stores with random ack stalls.
    for (int k = 0; k < 40; k++) begin
      ra = 16'($urandom);
      if ($urandom_range(0, 1) == 1) ra[2:0] = 3'b000;
      if ($urandom_range(0, 3) == 0) ra[15:4] = 12'hFFF;
      rd = {$urandom, $urandom};
      rs = 2'($urandom_range(0, 3));
      exp_n = model_err(ra, rs) ? 0 : model_count(rs);
      do_store(ra, rd, rs, -1, 0, 1'b1, 1'($urandom_range(0, 1)), n_seen, last);
      void'(chk("rand_beats", n_seen, exp_n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
